// File: rtl/bexkat1_bypass_if.sv
// bexkat1_bypass_if: decode-side operand/issue bundle for the bypass scoreboard
interface bexkat1_bypass_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 4,
  parameter int NUM_RD  = 2,
  parameter int NUM_STG = 3
);
  logic                      stall;
  logic                      flush;
  logic                      issue_valid;
  logic                      issue_wr;
  logic [REG_AW-1:0]         issue_waddr;
  logic                      issue_late;
  logic [NUM_RD*REG_AW-1:0]  rd_addr;
  logic [NUM_RD-1:0]         rd_use;
  logic [NUM_RD*DATA_W-1:0]  rf_data;
  logic [NUM_STG*DATA_W-1:0] stg_data;
  logic [NUM_RD*DATA_W-1:0]  rd_data;
  logic                      hazard_stall;
  logic [NUM_RD-1:0]         fwd_hit;
  modport master (
    output stall, flush, issue_valid, issue_wr, issue_waddr, issue_late,
           rd_addr, rd_use, rf_data, stg_data,
    input  rd_data, hazard_stall, fwd_hit
  );
  modport slave (
    input  stall, flush, issue_valid, issue_wr, issue_waddr, issue_late,
           rd_addr, rd_use, rf_data, stg_data,
    output rd_data, hazard_stall, fwd_hit
  );
endinterface

// File: rtl/bexkat1_bypass.sv
// bexkat1_bypass: in-flight write scoreboard with youngest-producer operand forwarding
module bexkat1_bypass #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int NUM_RD      = 2,
  parameter int NUM_STG     = 3,
  parameter int LATE_STG    = 1,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  bexkat1_bypass_if.slave bus
);
  logic [NUM_STG-1:0]       v, wr, late;
  logic [REG_AW-1:0]        waddr [NUM_STG];
  logic [NUM_RD-1:0]        sel, sel_rdy, hit;
  logic [DATA_W-1:0]        sel_data [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     hazard;
  always_ff @(posedge clk_i) begin
    if (!rst_i) v <= '0;
    else begin
      if (bus.flush) v[0] <= 1'b0;
      else if (!bus.stall) begin
        v[0]     <= bus.issue_valid && !hazard;
        wr[0]    <= bus.issue_wr;
        waddr[0] <= bus.issue_waddr;
        late[0]  <= bus.issue_late;
      end
      for (int k = 1; k < NUM_STG; k++)
        if (bus.flush && k < FLUSH_DEPTH) v[k] <= 1'b0;
        else if (!bus.stall) begin
          v[k]     <= v[k-1];
          wr[k]    <= wr[k-1];
          waddr[k] <= waddr[k-1];
          late[k]  <= late[k-1];
        end
    end
  end
  // scan oldest to youngest so the lowest matching stage is the one left selected
  always_comb begin
    sel     = '0;
    sel_rdy = '0;
    hit     = '0;
    rd_data = bus.rf_data;
    for (int p = 0; p < NUM_RD; p++) begin
      sel_data[p] = bus.rf_data[p*DATA_W +: DATA_W];
      for (int k = NUM_STG - 1; k >= 0; k--)
        if (v[k] && wr[k] && bus.rd_use[p] && waddr[k] == bus.rd_addr[p*REG_AW +: REG_AW]) begin
          sel[p]      = 1'b1;
          sel_rdy[p]  = !late[k] || k >= LATE_STG;
          sel_data[p] = bus.stg_data[k*DATA_W +: DATA_W];
        end
      hit[p] = sel[p] && sel_rdy[p];
      rd_data[p*DATA_W +: DATA_W] = hit[p] ? sel_data[p] : bus.rf_data[p*DATA_W +: DATA_W];
    end
    hazard = bus.issue_valid && |(sel & ~sel_rdy) && !bus.flush;
  end
  assign bus.rd_data      = rd_data;
  assign bus.fwd_hit      = hit;
  assign bus.hazard_stall = hazard;
endmodule

// File: tb/tb_bexkat1_bypass.sv
// tb_bexkat1_bypass: directed scoreboard bench for the bypass/hazard unit
module tb_bexkat1_bypass;
  typedef struct {
    string       name;
    logic [63:0] rd;
    logic [1:0]  hit;
    logic        hz;
    logic        cd;
    logic        ch;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t e;
  bexkat1_bypass_if #(.DATA_W(32), .REG_AW(4), .NUM_RD(2), .NUM_STG(3)) bus ();
  bexkat1_bypass #(
    .DATA_W(32), .REG_AW(4), .NUM_RD(2), .NUM_STG(3), .LATE_STG(1), .FLUSH_DEPTH(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (chk) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: check requested with no expectation queued");
      end else begin
        e = q.pop_front();
        checks++;
        if (bus.hazard_stall !== e.hz || (e.ch && bus.fwd_hit !== e.hit) || (e.cd && bus.rd_data !== e.rd)) begin
          errors++;
          $display("FAIL %s: got rd_data=%h fwd_hit=%b hazard=%b, expected rd_data=%h fwd_hit=%b hazard=%b",
                   e.name, bus.rd_data, bus.fwd_hit, bus.hazard_stall, e.rd, e.hit, e.hz);
        end
      end
    end
  task automatic idle();
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_wr = 1'b0;
    bus.issue_waddr = '0;
    bus.issue_late = 1'b0;
    bus.rd_use = '0;
    bus.rd_addr = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk = 1'b0;
    idle();
  endtask
  task automatic drain();
    repeat (3) tick();
  endtask
  task automatic issue(input logic [3:0] a, input logic l);
    bus.issue_valid = 1'b1;
    bus.issue_wr = 1'b1;
    bus.issue_waddr = a;
    bus.issue_late = l;
  endtask
  task automatic rd(input int p, input logic [3:0] a);
    bus.rd_use[p] = 1'b1;
    bus.rd_addr[p*4 +: 4] = a;
  endtask
  task automatic expect_all(input string n, input logic [31:0] d1, input logic [31:0] d0,
                            input logic [1:0] h, input logic hz);
    q.push_back('{n, {d1, d0}, h, hz, 1'b1, 1'b1});
    chk = 1'b1;
  endtask
  task automatic expect_hz(input string n, input logic [1:0] h, input logic hz, input logic ch);
    q.push_back('{n, 64'h0, h, hz, 1'b0, ch});
    chk = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    idle();
    bus.rf_data = {32'h0000_2222, 32'h0000_1111};
    bus.stg_data = '0;
    tick();
    tick();
    rd(0, 4'd1); rd(1, 4'd2);
    expect_all("reset_state", 32'h2222, 32'h1111, 2'b00, 1'b0);
    tick();
    rst_n = 1'b1;
    // ALU chain
    issue(4'd3, 1'b0);
    tick();
    rd(0, 4'd3);
    bus.stg_data[31:0] = 32'h1234;
    expect_all("alu_fwd", 32'h2222, 32'h1234, 2'b01, 1'b0);
    drain();
    // load-use: one stall cycle, then forward from stage 1
    issue(4'd5, 1'b1);
    tick();
    issue(4'd6, 1'b0); rd(0, 4'd5);
    expect_hz("load_use_stall", 2'b00, 1'b1, 1'b1);
    tick();
    issue(4'd6, 1'b0); rd(0, 4'd5);
    bus.stg_data[63:32] = 32'h5555;
    expect_all("load_use_fwd", 32'h2222, 32'h5555, 2'b01, 1'b0);
    drain();
    // youngest producer wins on both ports
    issue(4'd2, 1'b0);
    tick();
    tick();
    issue(4'd2, 1'b0);
    tick();
    rd(0, 4'd2); rd(1, 4'd2);
    bus.stg_data = {32'hAAAA, 32'h0, 32'hBBBB};
    expect_all("youngest", 32'hBBBB, 32'hBBBB, 2'b11, 1'b0);
    drain();
    issue(4'd2, 1'b0);
    tick();
    tick();
    issue(4'd2, 1'b1);
    tick();
    issue(4'd9, 1'b0); rd(0, 4'd2);
    expect_hz("young_late_stall", 2'b00, 1'b1, 1'b1);
    drain();
    // writeback-stage bypass, then regfile path after retire
    issue(4'd7, 1'b0);
    tick();
    tick();
    tick();
    bus.rf_data[31:0] = 32'h11;
    bus.stg_data[95:64] = 32'h55;
    rd(0, 4'd7);
    expect_all("wb_fwd", 32'h2222, 32'h55, 2'b01, 1'b0);
    tick();
    rd(0, 4'd7);
    expect_all("wb_retired", 32'h2222, 32'h11, 2'b00, 1'b0);
    drain();
    bus.rf_data = {32'h0000_2222, 32'h0000_1111};
    // flush squashes the pending stall
    issue(4'd4, 1'b1);
    tick();
    issue(4'd8, 1'b0); rd(0, 4'd4);
    bus.flush = 1'b1;
    expect_hz("flush_no_stall", 2'b00, 1'b0, 1'b1);
    tick();
    issue(4'd8, 1'b0); rd(0, 4'd4);
    expect_hz("post_flush", 2'b00, 1'b0, 1'b0);
    drain();
    issue(4'd4, 1'b1);
    tick();
    issue(4'd8, 1'b0); rd(0, 4'd4);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    expect_hz("flush_with_stall", 2'b00, 1'b0, 1'b1);
    tick();
    issue(4'd8, 1'b0); rd(0, 4'd4);
    expect_all("flush_stall_cleared", 32'h2222, 32'h1111, 2'b00, 1'b0);
    drain();
    // stall holds stage 0 and drops the issue
    issue(4'd3, 1'b0);
    tick();
    bus.stall = 1'b1;
    issue(4'd9, 1'b0);
    tick();
    rd(0, 4'd3); rd(1, 4'd9);
    bus.stg_data[31:0] = 32'h3333;
    expect_all("stall_hold", 32'h2222, 32'h3333, 2'b01, 1'b0);
    drain();
    // full pipeline, then reset during stall
    issue(4'd1, 1'b0);
    tick();
    issue(4'd2, 1'b0);
    tick();
    issue(4'd3, 1'b0);
    tick();
    bus.stg_data = {32'hA1, 32'hA2, 32'hA3};
    rd(0, 4'd1); rd(1, 4'd3);
    expect_all("full_pipe", 32'hA3, 32'hA1, 2'b11, 1'b0);
    tick();
    rst_n = 1'b0;
    bus.stall = 1'b1;
    tick();
    rst_n = 1'b1;
    issue(4'd5, 1'b0); rd(0, 4'd1); rd(1, 4'd2);
    expect_all("after_reset", 32'h2222, 32'h1111, 2'b00, 1'b0);
    drain();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
